// File: rtl/rv_pkg.sv
// Shared constants for the RISC-V core, plus the fetch FSM state type.
package rv_pkg;
  localparam int          ADDRESS_SIZE = 32;
  localparam int          WORD_SIZE    = 32;
  localparam logic [31:0] RESET_PC     = 32'h0000_0000;
  localparam logic [31:0] NOP_INST     = 32'h0000_0013;
  localparam int          INST_ALIGN   = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DROP = 2'd2
  } fetch_state_t;
endpackage

// File: rtl/instr_fetch_if.sv
// Fetch-stage bus: instruction-memory port, redirect input and decode-facing head entry.
interface instr_fetch_if #(
  parameter int ADDRESS_SIZE = rv_pkg::ADDRESS_SIZE,
  parameter int WORD_SIZE    = rv_pkg::WORD_SIZE
);
  logic                    o_imem_req;
  logic [ADDRESS_SIZE-1:0] o_imem_addr;
  logic                    i_imem_ack;
  logic [WORD_SIZE-1:0]    i_imem_data;
  logic                    i_redirect;
  logic [ADDRESS_SIZE-1:0] i_redirect_pc;
  logic                    i_id_ready;
  logic                    o_if_valid;
  logic [WORD_SIZE-1:0]    o_if_inst;
  logic [ADDRESS_SIZE-1:0] o_if_pc;

  modport master (
    output o_imem_req, o_imem_addr, o_if_valid, o_if_inst, o_if_pc,
    input  i_imem_ack, i_imem_data, i_redirect, i_redirect_pc, i_id_ready
  );

  modport slave (
    input  o_imem_req, o_imem_addr, o_if_valid, o_if_inst, o_if_pc,
    output i_imem_ack, i_imem_data, i_redirect, i_redirect_pc, i_id_ready
  );
endinterface

// File: rtl/fetch_queue.sv
// 2-entry {pc, inst} FIFO; head is always a register, showing {0, NOP} when empty.
// Latency: an enqueued entry reaches the head output one edge after enq (when empty).
// Backpressure: caller never enqueues when full without a same-cycle dequeue; flush wins.
module fetch_queue #(
  parameter int AW = rv_pkg::ADDRESS_SIZE,
  parameter int DW = rv_pkg::WORD_SIZE
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          enq,
  input  logic          deq,
  input  logic          flush,
  input  logic [AW-1:0] enq_pc,
  input  logic [DW-1:0] enq_inst,
  output logic [1:0]    occ,
  output logic          head_valid,
  output logic [AW-1:0] head_pc,
  output logic [DW-1:0] head_inst
);
  import rv_pkg::*;

  typedef struct packed {
    logic [AW-1:0] pc;
    logic [DW-1:0] inst;
  } entry_t;

  localparam entry_t EMPTY = entry_t'({{AW{1'b0}}, DW'(NOP_INST)});

  entry_t head_q, tail_q, din;

  assign din = '{pc: enq_pc, inst: enq_inst};

  // Shift-register organisation keeps the head output free of any read mux.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      occ    <= 2'd0;
      head_q <= EMPTY;
      tail_q <= EMPTY;
    end else if (flush) begin
      occ    <= 2'd0;
      head_q <= EMPTY;
    end else begin
      case ({enq, deq})
        2'b10: begin
          if (occ == 2'd0) head_q <= din;
          else             tail_q <= din;
          occ <= occ + 2'd1;
        end
        2'b01: begin
          head_q <= (occ == 2'd2) ? tail_q : EMPTY;
          occ    <= occ - 2'd1;
        end
        2'b11: begin
          if (occ == 2'd2) begin
            head_q <= tail_q;
            tail_q <= din;
          end else begin
            head_q <= din;
          end
        end
        default: ;
      endcase
    end
  end

  assign head_valid = (occ != 2'd0);
  assign head_pc    = head_q.pc;
  assign head_inst  = head_q.inst;
endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: owns fpc, drives the req/ack imem port and feeds decode from a 2-entry queue.
// Latency: o_if_valid rises the edge after an accepted ack; redirect-to-valid is 2+ cycles.
// Backpressure: a request is launched only when a queue slot is guaranteed; redirect flushes.
module instr_fetch #(
  parameter int                      ADDRESS_SIZE = rv_pkg::ADDRESS_SIZE,
  parameter int                      WORD_SIZE    = rv_pkg::WORD_SIZE,
  parameter logic [ADDRESS_SIZE-1:0] RESET_PC     = rv_pkg::RESET_PC
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  instr_fetch_if.master bus
);
  import rv_pkg::*;

  localparam logic [ADDRESS_SIZE-1:0] ALIGN_MASK = ADDRESS_SIZE'(INST_ALIGN - 1);

  fetch_state_t            state;
  logic [ADDRESS_SIZE-1:0] fpc, fpc_inc, redirect_tgt, addr_q;
  logic                    req_q;
  logic [1:0]              occ, occ_next;
  logic                    enq, deq, head_valid;

  assign deq          = head_valid && bus.i_id_ready;
  assign enq          = (state == ST_BUSY) && bus.i_imem_ack && !bus.i_redirect;
  assign occ_next     = occ + 2'(enq) - 2'(deq);
  assign fpc_inc      = fpc + ADDRESS_SIZE'(INST_ALIGN);
  assign redirect_tgt = bus.i_redirect_pc & ~ALIGN_MASK;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state  <= ST_IDLE;
      fpc    <= RESET_PC;
      req_q  <= 1'b0;
      addr_q <= RESET_PC;
    end else if (bus.i_redirect) begin
      fpc   <= redirect_tgt;
      req_q <= 1'b1;
      // An unacked request must still complete on the bus, so its data is dropped later.
      if (state == ST_IDLE || bus.i_imem_ack) begin
        state  <= ST_BUSY;
        addr_q <= redirect_tgt;
      end else begin
        state <= ST_DROP;
      end
    end else begin
      case (state)
        ST_IDLE: begin
          if (occ_next < 2'd2) begin
            state  <= ST_BUSY;
            req_q  <= 1'b1;
            addr_q <= fpc;
          end
        end
        ST_BUSY: begin
          if (bus.i_imem_ack) begin
            fpc    <= fpc_inc;
            addr_q <= fpc_inc;
            if (occ_next == 2'd2) begin
              state <= ST_IDLE;
              req_q <= 1'b0;
            end
          end
        end
        ST_DROP: begin
          if (bus.i_imem_ack) begin
            state  <= ST_BUSY;
            addr_q <= fpc;
          end
        end
        default: begin
          state <= ST_IDLE;
          req_q <= 1'b0;
        end
      endcase
    end
  end

  fetch_queue #(
    .AW (ADDRESS_SIZE),
    .DW (WORD_SIZE)
  ) u_queue (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .enq        (enq),
    .deq        (deq),
    .flush      (bus.i_redirect),
    .enq_pc     (fpc),
    .enq_inst   (bus.i_imem_data),
    .occ        (occ),
    .head_valid (head_valid),
    .head_pc    (bus.o_if_pc),
    .head_inst  (bus.o_if_inst)
  );

  assign bus.o_imem_req  = req_q;
  assign bus.o_imem_addr = addr_q;
  assign bus.o_if_valid  = head_valid;
endmodule
